vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
// - Generates the 640x480@60 raster (800x525 total) on the pixel clock.
// - Produces DrawX/DrawY/blank for the sprite mapper and ROM pixel stages.
// - Produces hs/vs/blank_d, delayed by PIPE_DLY cycles, to match the mapper's
//   2-cycle ROM + output-register latency at the VGA DAC pins.
// - Sits directly upstream of every *_pic_mapper; one instance per display.
// PARAMETERS
// H_ACTIVE  640  visible pixels per line
// H_FP      16   horizontal front porch (pixels)
// H_SYNC    96   horizontal sync width (pixels)
// H_BP      48   horizontal back porch (pixels)
// V_ACTIVE  480  visible lines per frame
// V_FP      10   vertical front porch (lines)
// V_SYNC    2    vertical sync width (lines)
// V_BP      33   vertical back porch (lines)
// SYNC_POL  0    asserted level of hs/vs (0 = active-low)
// PIPE_DLY  2    cycles of delay on hs/vs/blank_d; range 0..7
// PORTS
// vga_clk      in   1   pixel clock, rising edge
// reset_n      in   1   async active-low reset
// en           in   1   pixel enable; counters and delay line advance only when high
// DrawX        out  10  current column, 0..H_TOTAL-1
// DrawY        out  10  current line, 0..V_TOTAL-1
// blank        out  1   1 = visible pixel at (DrawX, DrawY), undelayed
// line_start   out  1   1 when DrawX==0 && en
// frame_start  out  1   1 when DrawX==0 && DrawY==0 && en
// hs           out  1   horizontal sync, delayed by PIPE_DLY
// vs           out  1   vertical sync, delayed by PIPE_DLY
// blank_d      out  1   blank, delayed by PIPE_DLY
// sync         out  1   constant 0 (no sync-on-green)
// BEHAVIOUR
// - Totals:
//   - H_TOTAL = sum of the H_* parameters (800).
//   - V_TOTAL = sum of the V_* parameters (525).
//   - Both totals must be <= 1024; elaboration $error otherwise.
// - Counters hc/vc are registered; DrawX=hc, DrawY=vc.
// - On en=1:
//   - hc <= (hc==H_TOTAL-1) ? 0 : hc+1.
//   - vc advances only when hc wraps, and wraps at V_TOTAL-1 to 0.
// - On en=0: hc, vc and the delay line all hold.
// - Combinational decodes from hc/vc, valid in the same cycle as DrawX/DrawY:
//   - blank = (hc<H_ACTIVE) && (vc<V_ACTIVE).
//   - hs_raw asserted for hc in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); 656..751 by default.
//   - vs_raw asserted for vc in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC); 490..491 by default.
// - Delay line: PIPE_DLY-deep shift register of {hs_raw, vs_raw, blank}.
//   - Shifts only when en=1.
//   - PIPE_DLY=0 is a combinational pass-through.
// - Reset (async assert, synchronous release on vga_clk):
//   - hc=0, vc=0.
//   - Every delay-line stage = {deasserted hs, deasserted vs, blank 0}.
//   - Outputs follow from these; sync=0 always.
// - First cycle after release: DrawX=0, DrawY=0, blank=1, frame_start=en.
// - Reset mid-frame aborts the frame with no partial-line recovery; the raster restarts at (0,0).
// - Simultaneous end-of-line and end-of-frame (hc=799, vc=524, en=1): next cycle is (0,0) with frame_start=1.
// TESTING
// - Release reset, en=1, run 420000 cycles:
//   - DrawX/DrawY trace 0..799 x 0..524 exactly once.
//   - frame_start pulses at cycles 0 and 420000.
//   - blank high on exactly 307200 cycles.
// - Line 0, PIPE_DLY=0: hs low for hc 656..751 (96 cycles); high otherwise.
// - Frame: vs low for exactly lines 490..491 (1600 cycles); blank=0 on all of lines 480..524.
// - PIPE_DLY=2: hs falls 2 cycles after hc=656; blank_d rises 2 cycles after (0,0) and falls 2 cycles after hc=640.
// - Hold en=0 for 5 cycles at hc=100, vc=7: DrawX/DrawY/hs/blank_d frozen; hc=101 on the first en=1 cycle.
// - Assert reset_n=0 at hc=400, vc=300, asynchronously mid-cycle:
//   - Outputs go to the reset state immediately.
//   - After release the raster resumes at (0,0).

Source files
------------

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the VGA timing generator and its consumers
// (sprite mappers, ROM pixel stages, DAC pin registers).
interface vga_timing_gen_if;
    logic       en;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       blank;
    logic       line_start;
    logic       frame_start;
    logic       hs;
    logic       vs;
    logic       blank_d;
    logic       sync;

    // Timing generator: takes the pixel enable, drives the raster outputs.
    modport master (
        input  en,
        output DrawX, DrawY, blank, line_start, frame_start,
        output hs, vs, blank_d, sync
    );

    // Consumer: supplies the pixel enable, observes the raster.
    modport slave (
        output en,
        input  DrawX, DrawY, blank, line_start, frame_start,
        input  hs, vs, blank_d, sync
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator. Horizontal/vertical counters give the current
// pixel position with an undelayed visibility flag; hs/vs/blank_d pass through
// a PIPE_DLY-deep delay line so they line up with the mapper's pixel latency.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter int SYNC_POL = 0,
    parameter int PIPE_DLY = 2
) (
    input  logic             vga_clk,
    input  logic             reset_n,
    vga_timing_gen_if.master vga
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counters are 10 bits wide, so neither total may exceed 1024.
    if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_total
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must be <= 1024");
    end
    if (PIPE_DLY < 0 || PIPE_DLY > 7) begin : g_bad_dly
        $error("vga_timing_gen: PIPE_DLY must be in 0..7");
    end

    // Decode boundaries held at 11 bits: a sync window may end exactly at 1024.
    localparam logic [9:0]  H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]  V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic        SYNC_ON  = (SYNC_POL != 0);
    // Idle stage contents: both syncs at their inactive level, not visible.
    localparam logic [2:0]  IDLE_STG = {~SYNC_ON, ~SYNC_ON, 1'b0};

    logic [9:0]  hc;
    logic [9:0]  vc;
    logic [10:0] hc_x;
    logic [10:0] vc_x;
    logic        vis;
    logic        hs_raw;
    logic        vs_raw;
    logic [2:0]  raw;
    logic [2:0]  dly_out;

    // Raster position: column advances on every enabled pixel, line on column wrap.
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hc <= '0;
            vc <= '0;
        end else if (vga.en) begin
            if (hc == H_LAST) begin
                hc <= '0;
                vc <= (vc == V_LAST) ? '0 : vc + 10'd1;
            end else begin
                hc <= hc + 10'd1;
            end
        end
    end

    assign hc_x   = {1'b0, hc};
    assign vc_x   = {1'b0, vc};
    assign vis    = (hc_x < H_VIS) && (vc_x < V_VIS);
    assign hs_raw = ((hc_x >= HS_BEG) && (hc_x < HS_END)) ? SYNC_ON : ~SYNC_ON;
    assign vs_raw = ((vc_x >= VS_BEG) && (vc_x < VS_END)) ? SYNC_ON : ~SYNC_ON;
    assign raw    = {hs_raw, vs_raw, vis};

    if (PIPE_DLY == 0) begin : g_pass
        assign dly_out = raw;
    end else begin : g_pipe
        for (genvar gi = 0; gi < PIPE_DLY; gi++) begin : g_stage
            logic [2:0] d;
            logic [2:0] q;

            if (gi == 0) begin : g_first
                assign d = raw;
            end else begin : g_next
                assign d = g_stage[gi-1].q;
            end

            // One delay stage; freezes with the counters when en is low.
            always_ff @(posedge vga_clk or negedge reset_n) begin
                if (!reset_n) begin
                    q <= IDLE_STG;
                end else if (vga.en) begin
                    q <= d;
                end
            end
        end
        assign dly_out = g_stage[PIPE_DLY-1].q;
    end

    assign vga.DrawX       = hc;
    assign vga.DrawY       = vc;
    assign vga.blank       = vis;
    assign vga.line_start  = (hc == 10'd0) && vga.en;
    assign vga.frame_start = (hc == 10'd0) && (vc == 10'd0) && vga.en;
    assign vga.hs          = dly_out[2];
    assign vga.vs          = dly_out[1];
    assign vga.blank_d     = dly_out[0];
    assign vga.sync        = 1'b0;

endmodule
